serial_weighted_acc: RTL and testbench
======================================

Name: serial_weighted_acc

Overview:
- Bit-serial weighted accumulator directly downstream of the 32-bit parallel-to-serial stage.
- Consumes the LSB-first true stream (Serial_In) and its two's-complement stream (Serial_In_neg) for one vector element at a time.
- Selects +x, -x or 0 per a reservoir weight code and adds the result bit-serially into a wide accumulator.
- After NUM_ELEM elements, presents one parallel dot-product result for the row.

Parameters:
- ACC_W, 40, accumulator/result width; must be >= 33.
- NUM_ELEM, 8, elements accumulated per row before Done; must be >= 1.
- CNT_W, $clog2(NUM_ELEM+1), element counter width (derived).

Ports:
- Clk  in  1  rising-edge clock; all sampling on posedge.
- Rst  in  1  asynchronous, active-high reset.
- Clear  in  1  synchronous: zero accumulator and element count, abort any element.
- Elem_Start  in  1  one-cycle pulse; begins one element; accepted only when Busy=0.
- Weight  in  2  latched at Elem_Start: 00=zero, 01=+x, 11=-x, 10=reserved (treated as 00).
- Serial_In  in  1  upstream true serial bit, LSB first.
- Serial_In_neg  in  1  upstream two's-complement serial bit, LSB first.
- Busy  out  1  high while an element is being accumulated.
- Elem_Done  out  1  one-cycle pulse at end of each element.
- Done  out  1  one-cycle pulse when element NUM_ELEM completes.
- Result  out  ACC_W  final row sum; held until the next Done or Clear.
- Result_Valid  out  1  high from Done until Clear or the next accepted Elem_Start.

Behaviour:
- Rst (async): all outputs 0; accumulator, carry, bit counter and element count 0; state IDLE.
- States and transitions:
  - IDLE: Elem_Start accepted -> SHIFT.
  - SHIFT: 32 cycles -> EXT.
  - EXT: ACC_W-32 cycles -> IDLE.
- Elem_Start accepted at edge E0: latch Weight, clear carry, Busy=1, Result_Valid=0.
- Operand bit per cycle:
  - SHIFT: bit k (k=0..31) sampled at edge E(k+1).
  - Weight 01 -> Serial_In; 11 -> Serial_In_neg; 00/10 -> 0.
  - EXT: operand = registered copy of the operand bit sampled at E32 (sign extension).
- Accumulate step, every SHIFT/EXT edge:
  - s = acc[0]^op^c; c <= majority(acc[0],op,c); acc <= {s, acc[ACC_W-1:1]}.
  - After ACC_W steps the accumulator is realigned.
- Final step at edge E(ACC_W):
  - Busy<=0, Elem_Done<=1, element count +1.
  - If count reaches NUM_ELEM: Done<=1; Result<=final acc value including this step's bit; Result_Valid<=1; acc and count reset to 0 for the next row.
- Latency: Elem_Done/Done visible ACC_W cycles after acceptance. Next Elem_Start accepted at E(ACC_W+1) earliest; back-to-back elements allowed.
- Arithmetic: modulo 2^ACC_W, wraps silently, no overflow flag. Upstream negation of 0x80000000 is 0x80000000 and is accumulated as -2^31.
- Elem_Start while Busy=1: ignored, no state change.
- Clear: highest synchronous priority. Any state -> IDLE; acc, carry, count, Busy, Result_Valid = 0. Result is held. Clear and Elem_Start in the same cycle: Clear wins, Elem_Start dropped.
- Rst mid-element: immediate return to reset values; partial sum discarded.
- Serial inputs are don't-care outside SHIFT.

Test Plan:
- Assert Rst mid-run -> all outputs 0 immediately; after release, Busy=0, Result=0, Result_Valid=0.
- NUM_ELEM=1, Weight=01, stream 5 -> Elem_Done and Done at E40, Result=0x0000000005, Result_Valid=1.
- NUM_ELEM=1, Weight=11, neg stream 0xFFFFFFFB -> Result=0xFFFFFFFFFB (-5).
- NUM_ELEM=4, back-to-back elements +7, -3, Weight 00 with 100, +0x7FFFFFFF -> 4 Elem_Done pulses, 1 Done, Result=0x0080000003.
- Clear at cycle 10 of an element -> Busy=0 next cycle; following single +1 element with NUM_ELEM=1 gives Result=1. Extra Elem_Start pulses while Busy=1 have no effect.
- NUM_ELEM=2, Weight=11 with 0x80000000 twice -> Result=0xFF00000000 (-2^32). Clear+Elem_Start in the same cycle -> no element started.

Source files
------------

// File: rtl/serial_weighted_acc.sv
// Bit-serial weighted accumulator. Each element takes ACC_W cycles: 32 cycles
// of LSB-first serial operand bits followed by ACC_W-32 cycles of sign
// extension. The accumulator rotates one bit per cycle through a full adder,
// so after ACC_W steps it is back in alignment. Every NUM_ELEM elements the
// row sum is published on Result.
module serial_weighted_acc #(
  parameter int ACC_W    = 40,
  parameter int NUM_ELEM = 8,
  parameter int CNT_W    = $clog2(NUM_ELEM + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clear,
  input  logic             Elem_Start,
  input  logic [1:0]       Weight,
  input  logic             Serial_In,
  input  logic             Serial_In_neg,
  output logic             Busy,
  output logic             Elem_Done,
  output logic             Done,
  output logic [ACC_W-1:0] Result,
  output logic             Result_Valid
);

  localparam int BCNT_W = $clog2(ACC_W);
  localparam logic [BCNT_W-1:0] SHIFT_LAST = BCNT_W'(31);
  localparam logic [BCNT_W-1:0] STEP_LAST  = BCNT_W'(ACC_W - 1);
  localparam logic [CNT_W-1:0]  ELEM_LAST  = CNT_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, EXT} state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic              carry;
  logic [BCNT_W-1:0] bcnt;
  logic [CNT_W-1:0]  ecnt;
  logic              sel_pos;
  logic              sel_neg;
  logic              op_ext;

  logic              op_bit;
  logic              sum_bit;
  logic              carry_next;
  logic [ACC_W-1:0]  acc_next;

  // Operand mux: live serial bit during SHIFT, held sign bit during EXT.
  // Reserved weight 10 never sets either select, so it contributes zero.
  assign op_bit     = (state == SHIFT) ? ((sel_pos & Serial_In) | (sel_neg & Serial_In_neg))
                                       : op_ext;
  assign sum_bit    = acc[0] ^ op_bit ^ carry;
  assign carry_next = (acc[0] & op_bit) | (acc[0] & carry) | (op_bit & carry);
  assign acc_next   = {sum_bit, acc[ACC_W-1:1]};

  // Control FSM, serial adder datapath and registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      acc          <= '0;
      carry        <= 1'b0;
      bcnt         <= '0;
      ecnt         <= '0;
      sel_pos      <= 1'b0;
      sel_neg      <= 1'b0;
      op_ext       <= 1'b0;
      Busy         <= 1'b0;
      Elem_Done    <= 1'b0;
      Done         <= 1'b0;
      Result       <= '0;
      Result_Valid <= 1'b0;
    end else begin
      Elem_Done <= 1'b0;
      Done      <= 1'b0;
      if (Clear) begin
        // Abort everything except the last published Result.
        state        <= IDLE;
        acc          <= '0;
        carry        <= 1'b0;
        bcnt         <= '0;
        ecnt         <= '0;
        Busy         <= 1'b0;
        Result_Valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Elem_Start) begin
              sel_pos      <= (Weight == 2'b01);
              sel_neg      <= (Weight == 2'b11);
              carry        <= 1'b0;
              bcnt         <= '0;
              Busy         <= 1'b1;
              Result_Valid <= 1'b0;
              state        <= SHIFT;
            end
          end
          SHIFT: begin
            acc   <= acc_next;
            carry <= carry_next;
            bcnt  <= bcnt + 1'b1;
            if (bcnt == SHIFT_LAST) begin
              // Bit 31 is the sign; replay it for the extension phase.
              op_ext <= op_bit;
              state  <= EXT;
            end
          end
          EXT: begin
            acc   <= acc_next;
            carry <= carry_next;
            bcnt  <= bcnt + 1'b1;
            if (bcnt == STEP_LAST) begin
              state     <= IDLE;
              bcnt      <= '0;
              Busy      <= 1'b0;
              Elem_Done <= 1'b1;
              if (ecnt == ELEM_LAST) begin
                Done         <= 1'b1;
                Result       <= acc_next;
                Result_Valid <= 1'b1;
                acc          <= '0;
                ecnt         <= '0;
              end else begin
                ecnt <= ecnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_weighted_acc.sv
// Directed bench for serial_weighted_acc. Three instances (NUM_ELEM = 1, 2, 4)
// share one stimulus bus; each scenario checks the instance whose row length
// it targets and uses Clear to realign the others.
module tb_serial_weighted_acc;

  localparam int ACC_W = 40;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             Clear = 1'b0;
  logic             Elem_Start = 1'b0;
  logic [1:0]       Weight = 2'b00;
  logic             Serial_In = 1'b0;
  logic             Serial_In_neg = 1'b0;

  logic             busy1, ed1, dn1, rv1;
  logic             busy2, ed2, dn2, rv2;
  logic             busy4, ed4, dn4, rv4;
  logic [ACC_W-1:0] res1, res2, res4;

  int checks = 0;
  int errors = 0;
  int ed4_n = 0;
  int dn4_n = 0;
  logic busy39, ed39, rv_at_start;

  always #5 Clk = ~Clk;

  serial_weighted_acc #(.ACC_W(ACC_W), .NUM_ELEM(1)) u1 (
    .Clk(Clk), .Rst(Rst), .Clear(Clear), .Elem_Start(Elem_Start), .Weight(Weight),
    .Serial_In(Serial_In), .Serial_In_neg(Serial_In_neg), .Busy(busy1),
    .Elem_Done(ed1), .Done(dn1), .Result(res1), .Result_Valid(rv1));

  serial_weighted_acc #(.ACC_W(ACC_W), .NUM_ELEM(2)) u2 (
    .Clk(Clk), .Rst(Rst), .Clear(Clear), .Elem_Start(Elem_Start), .Weight(Weight),
    .Serial_In(Serial_In), .Serial_In_neg(Serial_In_neg), .Busy(busy2),
    .Elem_Done(ed2), .Done(dn2), .Result(res2), .Result_Valid(rv2));

  serial_weighted_acc #(.ACC_W(ACC_W), .NUM_ELEM(4)) u4 (
    .Clk(Clk), .Rst(Rst), .Clear(Clear), .Elem_Start(Elem_Start), .Weight(Weight),
    .Serial_In(Serial_In), .Serial_In_neg(Serial_In_neg), .Busy(busy4),
    .Elem_Done(ed4), .Done(dn4), .Result(res4), .Result_Valid(rv4));

  // Pulse counters for the four-element row.
  always @(negedge Clk) begin
    if (ed4) ed4_n++;
    if (dn4) dn4_n++;
  end

  task automatic chk(input string nm, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pulse_clear();
    @(negedge Clk); Clear = 1'b1;
    @(negedge Clk); Clear = 1'b0;
  endtask

  // One element: start pulse, 32 serial bits, then the extension phase.
  // Returns #1 after the final step edge. With spam set, extra Elem_Start
  // pulses carrying a different weight are issued mid-element.
  task automatic run_elem(input logic [1:0] w, input logic [31:0] x, input bit spam);
    logic [31:0] nx;
    nx = ~x + 32'd1;
    @(negedge Clk); Elem_Start = 1'b1; Weight = w;
    @(posedge Clk); #1 rv_at_start = rv1;
    for (int k = 0; k < 32; k++) begin
      @(negedge Clk);
      Elem_Start = spam && (k == 5 || k == 20);
      if (spam) Weight = 2'b11;
      Serial_In = x[k];
      Serial_In_neg = nx[k];
      @(posedge Clk);
    end
    @(negedge Clk); Elem_Start = 1'b0; Serial_In = 1'b1; Serial_In_neg = 1'b1;
    for (int j = 0; j < ACC_W - 32; j++) begin
      @(posedge Clk); #1;
      if (j == ACC_W - 34) begin busy39 = busy1; ed39 = ed1; end
    end
  endtask

  typedef struct {
    logic [1:0]       w;
    logic [31:0]      x;
    logic [ACC_W-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ed_base, dn_base;
    vecs[0] = '{2'b01, 32'd5,          40'h0000000005};
    vecs[1] = '{2'b11, 32'd5,          40'hFFFFFFFFFB};
    vecs[2] = '{2'b00, 32'd100,        40'h0000000000};
    vecs[3] = '{2'b10, 32'd100,        40'h0000000000};
    vecs[4] = '{2'b01, 32'hFFFFFFFF,   40'hFFFFFFFFFF};
    vecs[5] = '{2'b11, 32'hFFFFFFFF,   40'h0000000001};
    vecs[6] = '{2'b01, 32'h80000000,   40'hFF80000000};
    vecs[7] = '{2'b11, 32'h7FFFFFFF,   40'hFF80000001};
    vecs[8] = '{2'b01, 32'h7FFFFFFF,   40'h007FFFFFFF};

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_elem_done", ed1, 0);
    chk("rst_done", dn1, 0);
    chk("rst_result", res1, 0);
    chk("rst_valid", rv1, 0);
    @(negedge Clk); Rst = 1'b0;

    // Single-element rows, one vector per row
    foreach (vecs[i]) begin
      run_elem(vecs[i].w, vecs[i].x, 1'b0);
      chk($sformatf("v%0d_result", i), res1, vecs[i].exp);
      chk($sformatf("v%0d_done", i), dn1, 1);
      chk($sformatf("v%0d_elem_done", i), ed1, 1);
      chk($sformatf("v%0d_valid", i), rv1, 1);
      chk($sformatf("v%0d_busy_end", i), busy1, 0);
      chk($sformatf("v%0d_busy_e39", i), busy39, 1);
      chk($sformatf("v%0d_ed_e39", i), ed39, 0);
      if (i > 0) chk($sformatf("v%0d_valid_drop", i), rv_at_start, 0);
    end

    // Four back-to-back elements: +7, -3, zero-weight 100, +0x7FFFFFFF
    pulse_clear();
    ed_base = ed4_n; dn_base = dn4_n;
    run_elem(2'b01, 32'd7, 1'b0);
    run_elem(2'b11, 32'd3, 1'b0);
    run_elem(2'b00, 32'd100, 1'b0);
    chk("row4_no_early_done", dn4, 0);
    run_elem(2'b01, 32'h7FFFFFFF, 1'b0);
    chk("row4_result", res4, 40'h0080000003);
    chk("row4_valid", rv4, 1);
    @(negedge Clk); #1;
    chk("row4_elem_done_cnt", ed4_n - ed_base, 4);
    chk("row4_done_cnt", dn4_n - dn_base, 1);

    // Clear ten cycles into an element, then a +1 element with stray starts
    pulse_clear();
    @(negedge Clk); Elem_Start = 1'b1; Weight = 2'b01;
    @(posedge Clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk); Elem_Start = 1'b0; Serial_In = 1'b1; Serial_In_neg = 1'b0;
      @(posedge Clk);
    end
    @(negedge Clk); Clear = 1'b1;
    @(posedge Clk); #1;
    chk("clr_busy", busy1, 0);
    chk("clr_valid", rv1, 0);
    chk("clr_result_held", res1, 40'h007FFFFFFF);
    @(negedge Clk); Clear = 1'b0;
    run_elem(2'b01, 32'd1, 1'b1);
    chk("clr_next_result", res1, 40'h0000000001);
    chk("clr_next_done", dn1, 1);

    // Two elements of -2^31 on the two-element row
    pulse_clear();
    run_elem(2'b11, 32'h80000000, 1'b0);
    chk("row2_first_no_done", dn2, 0);
    chk("row2_first_elem_done", ed2, 1);
    run_elem(2'b11, 32'h80000000, 1'b0);
    chk("row2_result", res2, 40'hFF00000000);
    chk("row2_done", dn2, 1);

    // Clear together with Elem_Start: start is dropped
    @(negedge Clk); Clear = 1'b1; Elem_Start = 1'b1; Weight = 2'b01;
    @(posedge Clk); #1;
    chk("clr_start_busy", busy1, 0);
    @(negedge Clk); Clear = 1'b0; Elem_Start = 1'b0;
    @(posedge Clk); #1;
    chk("clr_start_busy_next", busy2, 0);
    chk("clr_start_valid", rv2, 0);
    chk("clr_start_result_held", res2, 40'hFF00000000);

    // Reset mid-element
    @(negedge Clk); Elem_Start = 1'b1; Weight = 2'b01;
    @(negedge Clk); Elem_Start = 1'b0;
    repeat (5) @(negedge Clk);
    chk("pre_rst_busy", busy2, 1);
    Rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy2, 0);
    chk("mid_rst_result", res2, 0);
    chk("mid_rst_valid", rv2, 0);
    @(negedge Clk); Rst = 1'b0;
    @(posedge Clk); #1;
    chk("post_rst_busy", busy1, 0);
    chk("post_rst_result", res1, 0);
    chk("post_rst_valid", rv1, 0);
    run_elem(2'b01, 32'd5, 1'b0);
    chk("post_rst_elem", res1, 40'h0000000005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
